// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache controller.
//   state_e        : controller FSM states
//   S_CNT_DEFAULT  : default width of the saturating performance counters
//   ctrl_t         : bundle of datapath control strobes
//   ctrl_default() : control values that apply when no state asserts anything
package cache_ctrl_pkg;

  localparam int S_CNT_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TAG_CHECK = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_FILL      = 3'd3,
    ST_REREAD    = 3'd4
  } state_e;

  typedef struct packed {
    logic upstream_resp;
    logic downstream_read;
    logic downstream_write;
    logic cache_read;
    logic cache_load_en;
    logic downstream_address_sel;
    logic ld_wb;
    logic ld_LRU;
    logic new_dirty;
    logic wb_required;
  } ctrl_t;

  // The data array is always being read so tag/valid/dirty status is ready
  // for the next tag check; every other strobe idles low.
  function automatic ctrl_t ctrl_default();
    ctrl_t c;
    c            = '0;
    c.cache_read = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/cache_control_core_sat_counter.sv
// Saturating up-counter used for the cache performance statistics.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the count
//   inc_i    : increment request for this cycle
//   count_o  : current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cache_control_core.sv
// Cache controller FSM: sequences tag check, dirty-line writeback, line fill
// and re-read for one upstream request at a time, and keeps hit / miss /
// writeback statistics.
//   clk, rst                         : clock, synchronous active-high reset
//   upstream_read, upstream_write    : request strobes, held until upstream_resp
//   upstream_resp                    : one-cycle completion pulse
//   downstream_read/_write           : line fill / writeback requests
//   downstream_resp                  : downstream completion pulse
//   hit, valid, dirty                : datapath status for the buffered address
//   cache_read ... wb_required       : datapath control strobes
//   hit_count, miss_count, wb_count  : saturating performance counters
module cache_control_core
  import cache_ctrl_pkg::*;
#(
  parameter int s_cnt = S_CNT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upstream_read,
  input  logic             upstream_write,
  output logic             upstream_resp,
  output logic             downstream_read,
  output logic             downstream_write,
  input  logic             downstream_resp,
  input  logic             hit,
  input  logic             valid,
  input  logic             dirty,
  output logic             cache_read,
  output logic             cache_load_en,
  output logic             downstream_address_sel,
  output logic             ld_wb,
  output logic             ld_LRU,
  output logic             new_dirty,
  output logic             wb_required,
  output logic [s_cnt-1:0] hit_count,
  output logic [s_cnt-1:0] miss_count,
  output logic [s_cnt-1:0] wb_count
);

  state_e state_q;
  state_e state_d;

  // Set once a fill has completed for the current request: the tag check
  // that follows is the same request, so a miss there is not counted again.
  logic   refill_q;
  logic   refill_d;

  ctrl_t  ctrl;
  logic   is_write;
  logic   inc_hit;
  logic   inc_miss;
  logic   inc_wb;

  // A request with both strobes high is handled as a write.
  assign is_write = upstream_write;

  always_comb begin
    ctrl     = ctrl_default();
    state_d  = state_q;
    refill_d = refill_q;
    inc_hit  = 1'b0;
    inc_miss = 1'b0;
    inc_wb   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        refill_d = 1'b0;
        if (upstream_read || upstream_write) begin
          state_d = ST_TAG_CHECK;
        end
      end

      ST_TAG_CHECK: begin
        if (hit) begin
          ctrl.upstream_resp = 1'b1;
          ctrl.ld_LRU        = 1'b1;
          if (is_write) begin
            ctrl.cache_load_en = 1'b1;
            ctrl.new_dirty     = 1'b1;
          end
          inc_hit  = 1'b1;
          refill_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (valid && dirty) begin
          // Victim is dirty: capture it into the writeback buffer first.
          ctrl.ld_wb       = 1'b1;
          ctrl.wb_required = 1'b1;
          inc_miss         = !refill_q;
          inc_wb           = !refill_q;
          state_d          = ST_WRITEBACK;
        end else begin
          inc_miss = !refill_q;
          state_d  = ST_FILL;
        end
      end

      ST_WRITEBACK: begin
        // Address mux selects the victim's address for the writeback.
        ctrl.downstream_write       = 1'b1;
        ctrl.downstream_address_sel = 1'b1;
        if (downstream_resp) begin
          state_d = ST_FILL;
        end
      end

      ST_FILL: begin
        ctrl.downstream_read = 1'b1;
        if (downstream_resp) begin
          // Fill data lands in the array as a clean line.
          ctrl.cache_load_en = 1'b1;
          ctrl.new_dirty     = 1'b0;
          refill_d           = 1'b1;
          state_d            = ST_REREAD;
        end
      end

      ST_REREAD: begin
        // One cycle for the array to present the freshly filled line.
        state_d = ST_TAG_CHECK;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset kills any in-flight transaction immediately: no array write,
    // no statistics update and no downstream request in the reset cycle.
    if (rst) begin
      ctrl     = ctrl_default();
      inc_hit  = 1'b0;
      inc_miss = 1'b0;
      inc_wb   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      refill_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      refill_q <= refill_d;
    end
  end

  assign upstream_resp          = ctrl.upstream_resp;
  assign downstream_read        = ctrl.downstream_read;
  assign downstream_write       = ctrl.downstream_write;
  assign cache_read             = ctrl.cache_read;
  assign cache_load_en          = ctrl.cache_load_en;
  assign downstream_address_sel = ctrl.downstream_address_sel;
  assign ld_wb                  = ctrl.ld_wb;
  assign ld_LRU                 = ctrl.ld_LRU;
  assign new_dirty              = ctrl.new_dirty;
  assign wb_required            = ctrl.wb_required;

  sat_counter #(.W(s_cnt)) u_hit_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (inc_hit),
    .count_o (hit_count)
  );

  sat_counter #(.W(s_cnt)) u_miss_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (inc_miss),
    .count_o (miss_count)
  );

  sat_counter #(.W(s_cnt)) u_wb_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (inc_wb),
    .count_o (wb_count)
  );

endmodule

// File: tb/tb_cache_control_core.sv
module tb_cache_control_core;

  localparam int S_CNT   = 4;
  localparam int S_SMALL = 2;

  logic clk = 1'b0;
  logic rst;
  logic upstream_read, upstream_write, downstream_resp;
  logic hit, valid, dirty;

  logic upstream_resp, downstream_read, downstream_write, cache_read;
  logic cache_load_en, downstream_address_sel, ld_wb, ld_LRU, new_dirty, wb_required;
  logic [S_CNT-1:0] hit_count, miss_count, wb_count;

  logic s_upstream_resp, s_downstream_read, s_downstream_write, s_cache_read;
  logic s_cache_load_en, s_downstream_address_sel, s_ld_wb, s_ld_LRU, s_new_dirty, s_wb_required;
  logic [S_SMALL-1:0] s_hit_count, s_miss_count, s_wb_count;

  int n_chk  = 0;
  int n_fail = 0;
  int m_hit  = 0;
  int m_miss = 0;
  int m_wb   = 0;

  always #5 clk = ~clk;

  cache_control_core #(.s_cnt(S_CNT)) dut (
    .clk(clk), .rst(rst),
    .upstream_read(upstream_read), .upstream_write(upstream_write),
    .upstream_resp(upstream_resp),
    .downstream_read(downstream_read), .downstream_write(downstream_write),
    .downstream_resp(downstream_resp),
    .hit(hit), .valid(valid), .dirty(dirty),
    .cache_read(cache_read), .cache_load_en(cache_load_en),
    .downstream_address_sel(downstream_address_sel),
    .ld_wb(ld_wb), .ld_LRU(ld_LRU), .new_dirty(new_dirty), .wb_required(wb_required),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  cache_control_core #(.s_cnt(S_SMALL)) dut_small (
    .clk(clk), .rst(rst),
    .upstream_read(upstream_read), .upstream_write(upstream_write),
    .upstream_resp(s_upstream_resp),
    .downstream_read(s_downstream_read), .downstream_write(s_downstream_write),
    .downstream_resp(downstream_resp),
    .hit(hit), .valid(valid), .dirty(dirty),
    .cache_read(s_cache_read), .cache_load_en(s_cache_load_en),
    .downstream_address_sel(s_downstream_address_sel),
    .ld_wb(s_ld_wb), .ld_LRU(s_ld_LRU), .new_dirty(s_new_dirty), .wb_required(s_wb_required),
    .hit_count(s_hit_count), .miss_count(s_miss_count), .wb_count(s_wb_count)
  );

  wire [9:0] ov   = {upstream_resp, downstream_read, downstream_write, cache_read,
                     cache_load_en, downstream_address_sel, ld_wb, ld_LRU,
                     new_dirty, wb_required};
  wire [9:0] s_ov = {s_upstream_resp, s_downstream_read, s_downstream_write, s_cache_read,
                     s_cache_load_en, s_downstream_address_sel, s_ld_wb, s_ld_LRU,
                     s_new_dirty, s_wb_required};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Saturating count as seen by a counter of width w.
  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Expected control vector; cache_read is always high.
  function automatic logic [9:0] ev(input bit ursp, input bit dr, input bit dw, input bit cle,
                                    input bit das, input bit lwb, input bit llru,
                                    input bit nd, input bit wbr);
    return {ursp, dr, dw, 1'b1, cle, das, lwb, llru, nd, wbr};
  endfunction

  task automatic drv(input bit rd, input bit wr, input bit h, input bit v, input bit d,
                     input bit resp);
    upstream_read   = rd;
    upstream_write  = wr;
    hit             = h;
    valid           = v;
    dirty           = d;
    downstream_resp = resp;
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Inputs for this cycle are already driven; check, then move to next negedge.
  task automatic step(input logic [9:0] e, input string tag, input bit cnt);
    #1;
    check_val(tag, {22'd0, ov}, {22'd0, e});
    check_val({tag, "_small"}, {22'd0, s_ov}, {22'd0, e});
    if (cnt) begin
      check_val("hit_count",        {28'd0, hit_count},    sat(m_hit,  S_CNT));
      check_val("miss_count",       {28'd0, miss_count},   sat(m_miss, S_CNT));
      check_val("wb_count",         {28'd0, wb_count},     sat(m_wb,   S_CNT));
      check_val("hit_count_small",  {30'd0, s_hit_count},  sat(m_hit,  S_SMALL));
      check_val("miss_count_small", {30'd0, s_miss_count}, sat(m_miss, S_SMALL));
      check_val("wb_count_small",   {30'd0, s_wb_count},   sat(m_wb,   S_SMALL));
    end
    @(negedge clk);
  endtask

  // One complete upstream request: miss selects the miss path, vl/dt are the
  // victim status, wl/fl the downstream latencies in cycles.
  task automatic txn(input bit rd, input bit wr, input bit miss, input bit vl, input bit dt,
                     input int wl, input int fl);
    bit dmiss;
    dmiss = miss && vl && dt;
    drv(rd, wr, rb(), rb(), rb(), rb());
    step(ev(0,0,0,0,0,0,0,0,0), "idle_req", 1'b0);
    if (miss) begin
      drv(rd, wr, 1'b0, vl, dt, rb());
      step(ev(0,0,0,0,0,dmiss,0,0,dmiss), "tc_miss", 1'b0);
      if (dmiss) begin
        for (int k = 1; k <= wl; k++) begin
          drv(rd, wr, rb(), rb(), rb(), k == wl);
          step(ev(0,0,1,0,1,0,0,0,0), "writeback", 1'b0);
        end
      end
      for (int k = 1; k <= fl; k++) begin
        drv(rd, wr, rb(), rb(), rb(), k == fl);
        step(ev(0,1,0,(k == fl),0,0,0,0,0), "fill", 1'b0);
      end
      drv(rd, wr, rb(), rb(), rb(), rb());
      step(ev(0,0,0,0,0,0,0,0,0), "reread", 1'b0);
      m_miss++;
      if (dmiss) m_wb++;
    end
    drv(rd, wr, 1'b1, 1'b1, rb(), rb());
    step(ev(1,0,0,wr,0,0,1,wr,0), "tc_hit", 1'b0);
    m_hit++;
    drv(1'b0, 1'b0, rb(), rb(), rb(), rb());
    step(ev(0,0,0,0,0,0,0,0,0), "idle_done", 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drv(1, 0, 1, 1, 1, 1);
    step(ev(0,0,0,0,0,0,0,0,0), "in_reset", 1'b1);
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    step(ev(0,0,0,0,0,0,0,0,0), "reset_state", 1'b1);

    // Five read hits: narrow counters must stick at 3.
    for (int i = 0; i < 5; i++) txn(1, 0, 0, 0, 0, 1, 1);
    // Write hit, read+write treated as write, clean miss, dirty miss.
    txn(0, 1, 0, 0, 0, 1, 1);
    txn(1, 1, 0, 0, 0, 1, 1);
    txn(1, 0, 1, 1, 0, 1, 5);
    txn(1, 0, 1, 1, 1, 3, 4);
    txn(0, 1, 1, 0, 1, 2, 2);

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      txn(kind != 1, kind != 0, rb(), rb(), rb(),
          $urandom_range(1, 6), $urandom_range(1, 6));
      if (rb()) begin
        drv(0, 0, rb(), rb(), rb(), rb());
        step(ev(0,0,0,0,0,0,0,0,0), "idle_gap", 1'b0);
      end
    end

    // Reset in the third FILL cycle, with a coincident downstream_resp.
    drv(1, 0, 0, 0, 0, 0);
    step(ev(0,0,0,0,0,0,0,0,0), "idle_req", 1'b0);
    drv(1, 0, 0, 1, 0, 0);
    step(ev(0,0,0,0,0,0,0,0,0), "tc_miss", 1'b0);
    for (int k = 1; k <= 2; k++) begin
      drv(1, 0, 0, 0, 0, 0);
      step(ev(0,1,0,0,0,0,0,0,0), "fill_pre_rst", 1'b0);
    end
    drv(1, 0, 0, 0, 0, 1);
    rst = 1'b1;
    #1;
    check_val("rst_fill_load_en", {31'd0, cache_load_en}, 32'd0);
    check_val("rst_fill_load_en_small", {31'd0, s_cache_load_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hit = 0; m_miss = 0; m_wb = 0;
    drv(0, 0, 0, 0, 0, 1);
    step(ev(0,0,0,0,0,0,0,0,0), "post_rst", 1'b1);

    // Controller resumes normally after the abandoned fill.
    txn(1, 0, 1, 1, 0, 1, 2);
    txn(0, 1, 0, 0, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_control_core.md
CACHE_CONTROL_CORE -- requirements
Module: cache_control_core

Interface
REQ-001 Parameter: s_cnt, default 16, width of each saturating performance counter.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 upstream_read / upstream_write  input  1 each  request strobes; requester holds them and the address stable until upstream_resp.
REQ-005 upstream_resp  output  1  one-cycle completion pulse.
REQ-006 downstream_read / downstream_write  output  1 each  line fill / writeback requests.
REQ-007 downstream_resp  input  1  downstream completion pulse.
REQ-008 hit, valid, dirty  input  1 each  datapath status for the buffered address and selected way.
REQ-009 cache_read, cache_load_en, downstream_address_sel, ld_wb, ld_LRU, new_dirty, wb_required  output  1 each  datapath controls.
REQ-010 hit_count, miss_count, wb_count  output  s_cnt each  performance counters.

Function
REQ-011 States SHALL be IDLE, TAG_CHECK, WRITEBACK, FILL, REREAD.
REQ-012 cache_read SHALL be 1 in every state; all other datapath controls default 0.
REQ-013 IDLE: upstream_read or upstream_write high -> TAG_CHECK next cycle; otherwise stay.
REQ-014 TAG_CHECK, hit=1: upstream_resp=1, ld_LRU=1; if write, also cache_load_en=1, new_dirty=1; -> IDLE; hit_count increments.
REQ-015 TAG_CHECK, hit=0, valid=1, dirty=1: ld_wb=1, wb_required=1, -> WRITEBACK; miss_count and wb_count increment.
REQ-016 TAG_CHECK, hit=0, otherwise: -> FILL; miss_count increments.
REQ-017 WRITEBACK: downstream_write=1, downstream_address_sel=1 until downstream_resp; on downstream_resp -> FILL (downstream_write deasserted next cycle).
REQ-018 FILL: downstream_read=1, downstream_address_sel=0; on downstream_resp: cache_load_en=1, new_dirty=0, -> REREAD.
REQ-019 REREAD: one idle cycle for array re-read, -> TAG_CHECK; that check SHALL hit and complete per REQ-014 without counting a second miss.
REQ-020 Hit latency: request seen in cycle N -> upstream_resp in cycle N+1.
REQ-021 upstream_read and upstream_write both high SHALL be treated as a write.
REQ-022 downstream_resp in IDLE, TAG_CHECK or REREAD SHALL be ignored.
REQ-023 Requests dropped in TAG_CHECK before completion are undefined; controller does not detect them.
REQ-024 Counters SHALL saturate at all-ones; no wrap-around.
REQ-025 downstream_read and downstream_write SHALL never be high together.
REQ-026 upstream_resp SHALL never be high outside TAG_CHECK.

Reset
REQ-027 rst high SHALL force state IDLE, counters to zero, and all outputs except cache_read to 0 from the next cycle.
REQ-028 Reset during WRITEBACK or FILL SHALL abandon the downstream transaction; no data array write occurs.

Structure
REQ-029 State enum and counter width default SHALL live in package cache_ctrl_pkg.
REQ-030 State register and next-state/output logic SHALL be in cache_control_core; the three counters SHALL use one sub-module, sat_counter.

Verification
REQ-031 Read hit: read in cycle 0, hit=1 in TAG_CHECK -> upstream_resp and ld_LRU in cycle 1, cache_load_en=0, hit_count=1.
REQ-032 Write hit: write, hit=1 -> cache_load_en=1, new_dirty=1, upstream_resp=1 in same cycle; state IDLE next.
REQ-033 Clean miss: hit=0, valid=1, dirty=0, downstream_resp after 5 cycles -> downstream_read high 5 cycles, cache_load_en pulse with new_dirty=0, REREAD, then hit completes; miss_count=1, wb_count=0.
REQ-034 Dirty miss: hit=0, valid=1, dirty=1 -> ld_wb, wb_required pulse; downstream_write with downstream_address_sel=1 until resp; then fill; wb_count=1.
REQ-035 Reset mid-FILL: rst in cycle 3 of FILL -> IDLE, downstream_read=0 next cycle, counters 0, no cache_load_en.
REQ-036 Saturation: s_cnt=2, five read hits -> hit_count=3.
